// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types: FSM state encoding, scancode prefixes, frame constants
// and the scancode FIFO entry layout.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   // start + 8 data + parity + stop
   localparam int unsigned PS2_FRAME_BITS = 11;
   localparam int unsigned PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

   localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_scan_t;

   // Odd parity over data byte plus parity bit
   function automatic logic odd_parity_ok(input logic [7:0] code, input logic par);
      return (^code) ^ par;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter; the output only
// follows the input after FILTER_LEN consecutive equal synchronised samples.
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             filt_q,  filt_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [CNT_W-1:0] cnt_inc;

   // Count samples that disagree with the filtered level; any agreeing sample restarts the run
   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      filt_d  = filt_q;
      cnt_d   = '0;
      cnt_inc = cnt_q + CNT_W'(1);
      if (sync2_q != filt_q) begin
         if (cnt_inc == CNT_W'(FILTER_LEN)) begin
            filt_d = sync2_q;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         filt_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout = filt_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: filtered lines, frame decode with error pulses and
// timeout, show-ahead receive FIFO and good-byte history.
// Define PS2_RX_SCANCODE_EN to fold E0/F0 prefixes into ext/brk flags on FIFO entries.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN  = 4,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned HIST_BYTES  = 2,
   parameter int unsigned TIMEOUT_CYC = 6000
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               ps2_clk,
   input  logic                               ps2_data,
   output logic [7:0]                         rx_data,
   output logic                               rx_ext,
   output logic                               rx_brk,
   output logic                               rx_valid,
   input  logic                               rx_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
   output logic [8*HIST_BYTES-1:0]            code_hist,
   output logic                               err_parity,
   output logic                               err_frame,
   output logic                               err_timeout,
   output logic                               overflow
);

   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned HW    = 8 * HIST_BYTES;
   localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned BIT_W = $clog2(PS2_DATA_BITS);
`ifdef PS2_RX_SCANCODE_EN
   localparam int unsigned ENTRY_W = $bits(ps2_scan_t);
`else
   localparam int unsigned ENTRY_W = 8;
`endif

   logic clk_f, data_f, fall_c;
   logic clk_prev_q, clk_prev_d;

   ps2_state_e       state_q,   state_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q,   shift_d;
   logic             par_q,     par_d;
   logic [TW-1:0]    tmo_q,     tmo_d;
   logic [HW-1:0]    hist_q,    hist_d;
   logic             err_par_q, err_par_d;
   logic             err_frm_q, err_frm_d;
   logic             err_tmo_q, err_tmo_d;
   logic             ovf_q,     ovf_d;
   logic             push_q,    push_d;
   logic [ENTRY_W-1:0] push_ent_q, push_ent_d;
   logic             good_c;
`ifdef PS2_RX_SCANCODE_EN
   logic             ext_q, ext_d;
   logic             brk_q, brk_d;
   ps2_scan_t        scan_c;
   ps2_scan_t        head_s;
`endif

   logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
   logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0]    wptr_q,  wptr_d;
   logic [AW-1:0]    rptr_q,  rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             pop_c, full_c, do_push_c;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (ps2_clk),
      .dout (clk_f)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (ps2_data),
      .dout (data_f)
   );

   assign fall_c = clk_prev_q & ~clk_f;

   // Frame decoder, timeout and good-byte dispatch
   always_comb begin
      clk_prev_d = clk_f;
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      tmo_d      = tmo_q;
      hist_d     = hist_q;
      err_par_d  = 1'b0;
      err_frm_d  = 1'b0;
      err_tmo_d  = 1'b0;
      push_d     = 1'b0;
      push_ent_d = push_ent_q;
      good_c     = 1'b0;
`ifdef PS2_RX_SCANCODE_EN
      ext_d      = ext_q;
      brk_d      = brk_q;
      scan_c     = '0;
`endif
      if (state_q == ST_IDLE) begin
         tmo_d = '0;
         if (fall_c && !data_f) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
         end
      end else if (fall_c) begin
         tmo_d = '0;
         case (state_q)
            ST_DATA: begin
               shift_d   = {data_f, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
               if (bit_cnt_q == BIT_W'(PS2_DATA_BITS - 1)) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               par_d   = data_f;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (!data_f)                             err_frm_d = 1'b1;
               else if (!odd_parity_ok(shift_q, par_q)) err_par_d = 1'b1;
               else                                     good_c    = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (tmo_q + TW'(1) == TW'(TIMEOUT_CYC)) begin
         err_tmo_d = 1'b1;
         state_d   = ST_IDLE;
         tmo_d     = '0;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end

      if (good_c) begin
         hist_d = HW'({hist_q, shift_q});
`ifdef PS2_RX_SCANCODE_EN
         if (shift_q == PS2_PFX_EXT) begin
            ext_d = 1'b1;
         end else if (shift_q == PS2_PFX_BRK) begin
            brk_d = 1'b1;
         end else begin
            scan_c.ext  = ext_q;
            scan_c.brk  = brk_q;
            scan_c.code = shift_q;
            push_d      = 1'b1;
            push_ent_d  = scan_c;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
         end
`else
         push_d     = 1'b1;
         push_ent_d = shift_q;
`endif
      end
`ifdef PS2_RX_SCANCODE_EN
      if (err_par_d || err_frm_d || err_tmo_d) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end
`endif
   end

   // FIFO: a push against a full FIFO survives only when the head is popped in the same cycle
   always_comb begin
      pop_c     = (count_q != '0) && rx_ready;
      full_c    = (count_q == CW'(FIFO_DEPTH));
      do_push_c = push_q && (!full_c || pop_c);
      ovf_d     = push_q && full_c && !pop_c;
      mem_d     = mem_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      if (do_push_c) begin
         mem_d[wptr_q] = push_ent_q;
         wptr_d        = wptr_q + AW'(1);
      end
      if (pop_c) rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(do_push_c) - CW'(pop_c);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_prev_q <= 1'b1;
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tmo_q      <= '0;
         hist_q     <= '0;
         err_par_q  <= 1'b0;
         err_frm_q  <= 1'b0;
         err_tmo_q  <= 1'b0;
         ovf_q      <= 1'b0;
         push_q     <= 1'b0;
         push_ent_q <= '0;
         mem_q      <= '{default: '0};
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
`ifdef PS2_RX_SCANCODE_EN
         ext_q      <= 1'b0;
         brk_q      <= 1'b0;
`endif
      end else begin
         clk_prev_q <= clk_prev_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tmo_q      <= tmo_d;
         hist_q     <= hist_d;
         err_par_q  <= err_par_d;
         err_frm_q  <= err_frm_d;
         err_tmo_q  <= err_tmo_d;
         ovf_q      <= ovf_d;
         push_q     <= push_d;
         push_ent_q <= push_ent_d;
         mem_q      <= mem_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
`ifdef PS2_RX_SCANCODE_EN
         ext_q      <= ext_d;
         brk_q      <= brk_d;
`endif
      end
   end

`ifdef PS2_RX_SCANCODE_EN
   assign head_s  = ps2_scan_t'(mem_q[rptr_q]);
   assign rx_data = head_s.code;
   assign rx_ext  = head_s.ext;
   assign rx_brk  = head_s.brk;
`else
   assign rx_data = mem_q[rptr_q];
   assign rx_ext  = 1'b0;
   assign rx_brk  = 1'b0;
`endif
   assign rx_valid    = (count_q != '0);
   assign fifo_count  = count_q;
   assign code_hist   = hist_q;
   assign err_parity  = err_par_q;
   assign err_frame   = err_frm_q;
   assign err_timeout = err_tmo_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised PS/2 frame stimulus with a queue-based reference model; a drain
// process pops and compares FIFO output independently of the frame driver.
module tb_ps2_rx_fifo;

   localparam int unsigned FILTER_LEN  = 4;
   localparam int unsigned FIFO_DEPTH  = 8;
   localparam int unsigned HIST_BYTES  = 3;
   localparam int unsigned TIMEOUT_CYC = 400;
   localparam int unsigned HP          = 20;
   localparam int unsigned CW          = $clog2(FIFO_DEPTH + 1);

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  ps2_clk;
   logic                  ps2_data;
   logic [7:0]            rx_data;
   logic                  rx_ext;
   logic                  rx_brk;
   logic                  rx_valid;
   logic                  rx_ready;
   logic [CW-1:0]         fifo_count;
   logic [8*HIST_BYTES-1:0] code_hist;
   logic                  err_parity;
   logic                  err_frame;
   logic                  err_timeout;
   logic                  overflow;

   always #5 clk = ~clk;

   ps2_rx_fifo #(
      .FILTER_LEN (FILTER_LEN),
      .FIFO_DEPTH (FIFO_DEPTH),
      .HIST_BYTES (HIST_BYTES),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .rx_data    (rx_data),
      .rx_ext     (rx_ext),
      .rx_brk     (rx_brk),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .fifo_count (fifo_count),
      .code_hist  (code_hist),
      .err_parity (err_parity),
      .err_frame  (err_frame),
      .err_timeout(err_timeout),
      .overflow   (overflow)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [9:0]  exp_q[$];
   logic [23:0] hist_m = '0;
   logic        ext_m  = 1'b0;
   logic        brk_m  = 1'b0;
   int e_par = 0, e_frm = 0, e_tmo = 0, e_ovf = 0;
   // Observed pulse-cycle counts
   int n_par = 0, n_frm = 0, n_tmo = 0, n_ovf = 0;
   bit drain_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         n_par += int'(err_parity);
         n_frm += int'(err_frame);
         n_tmo += int'(err_timeout);
         n_ovf += int'(overflow);
      end
   end

   // Drain / monitor: randomly assert ready, compare each handshaken head with the model
   initial begin
      logic [9:0] e;
      rx_ready = 1'b0;
      forever begin
         @(negedge clk);
         rx_ready = drain_en && rst_n && ($urandom_range(0, 3) != 0);
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pop: rx_data=0x%0h with empty model queue", rx_data);
            end else begin
               e = exp_q.pop_front();
               chk("pop.rx_data", 32'(rx_data), 32'(e[7:0]));
               chk("pop.rx_ext",  32'(rx_ext),  32'(e[9]));
               chk("pop.rx_brk",  32'(rx_brk),  32'(e[8]));
            end
         end
      end
   end

   task automatic clear_flags();
      ext_m = 1'b0;
      brk_m = 1'b0;
   endtask

   task automatic model_push(input logic [9:0] ent);
      if (exp_q.size() == FIFO_DEPTH && !drain_en) e_ovf++;
      else exp_q.push_back(ent);
   endtask

   task automatic model_good(input logic [7:0] b);
      hist_m = {hist_m[15:0], b};
`ifdef PS2_RX_SCANCODE_EN
      if (b == 8'hE0) ext_m = 1'b1;
      else if (b == 8'hF0) brk_m = 1'b1;
      else begin
         model_push({ext_m, brk_m, b});
         clear_flags();
      end
`else
      model_push({2'b00, b});
`endif
   endtask

   task automatic ps2_bit(input logic b);
      @(negedge clk);
      ps2_data = b;
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   // kind: 0 good, 1 parity error, 2 stop-bit error, 3 stop-bit and parity error
   task automatic send_frame(input logic [7:0] b, input int kind);
      logic par;
      logic stop;
      par  = ~(^b);
      if (kind == 1 || kind == 3) par = ~par;
      stop = (kind < 2);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(par);
      @(negedge clk);
      ps2_data = stop;
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b0;
      if (!stop) begin
         e_frm++;
         clear_flags();
      end else if (kind == 1) begin
         e_par++;
         clear_flags();
      end else begin
         model_good(b);
      end
      repeat (HP) @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (2 * HP) @(negedge clk);
   endtask

   task automatic checkpoint(input string tag);
      repeat (3) @(negedge clk);
      chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(exp_q.size()));
      chk({tag, ".rx_valid"},   32'(rx_valid),   32'(exp_q.size() != 0));
      chk({tag, ".code_hist"},  32'(code_hist),  32'(hist_m));
      chk({tag, ".err_parity"}, 32'(n_par), 32'(e_par));
      chk({tag, ".err_frame"},  32'(n_frm), 32'(e_frm));
      chk({tag, ".err_timeout"},32'(n_tmo), 32'(e_tmo));
      chk({tag, ".overflow"},   32'(n_ovf), 32'(e_ovf));
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      drain_en = 1'b1;
      while ((exp_q.size() != 0 || rx_valid) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: model queue=%0d rx_valid=%0b", exp_q.size(), rx_valid);
      end
      drain_en = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int kind;
      rst_n    = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (4) @(negedge clk);

      // Reset state
      chk("rst.rx_valid",   32'(rx_valid),   32'd0);
      chk("rst.fifo_count", 32'(fifo_count), 32'd0);
      chk("rst.code_hist",  32'(code_hist),  32'd0);
      chk("rst.rx_data",    32'(rx_data),    32'd0);
      chk("rst.rx_ext",     32'(rx_ext),     32'd0);
      chk("rst.rx_brk",     32'(rx_brk),     32'd0);
      chk("rst.errors",     32'({err_parity, err_frame, err_timeout, overflow}), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Single good frame
      send_frame(8'h1C, 0);
      checkpoint("good_1c");
      chk("good_1c.head", 32'(rx_data), 32'h1C);
      wait_drain();

      // Parity error
      send_frame(8'h1C, 1);
      checkpoint("parity_err");

      // Stop-bit error with bad parity: frame error wins
      send_frame(8'h3A, 3);
      checkpoint("frame_err");

      // Fill past depth with no consumer
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 0);
      checkpoint("overflow");
      wait_drain();
      checkpoint("overflow_drained");

      // Abandoned frame: start + 3 bits then silence
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      @(negedge clk);
      ps2_data = 1'b1;
      repeat (TIMEOUT_CYC / 2) @(negedge clk);
      checkpoint("timeout_early");
      e_tmo++;
      clear_flags();
      repeat (TIMEOUT_CYC) @(negedge clk);
      checkpoint("timeout");
      send_frame(8'h5A, 0);
      checkpoint("after_timeout");
      wait_drain();

      // Two-cycle clock glitch while data is low must not start a frame
      @(negedge clk);
      ps2_data = 1'b0;
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HP) @(negedge clk);
      ps2_data = 1'b1;
      repeat (TIMEOUT_CYC + 50) @(negedge clk);
      checkpoint("glitch");
      send_frame(8'h33, 0);
      checkpoint("after_glitch");
      wait_drain();

      // Extended break sequence
      send_frame(8'hE0, 0);
      send_frame(8'hF0, 0);
      send_frame(8'h75, 0);
      checkpoint("e0f075");
      chk("e0f075.hist24", 32'(code_hist[23:0]), 32'hE0F075);
      wait_drain();

      // Reset in the middle of a frame with data queued
      send_frame(8'h11, 0);
      send_frame(8'h22, 0);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst.fifo_count", 32'(fifo_count), 32'd0);
      chk("midrst.rx_valid",   32'(rx_valid),   32'd0);
      chk("midrst.code_hist",  32'(code_hist),  32'd0);
      exp_q.delete();
      hist_m = '0;
      clear_flags();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      send_frame(8'h5A, 0);
      checkpoint("after_midrst");
      wait_drain();

      // Random traffic: errors, prefixes and consumer on/off
      for (int f = 0; f < 40; f++) begin
         drain_en = ($urandom_range(0, 2) != 0);
         kind = $urandom_range(0, 9);
         if (kind > 3) kind = 0;
         if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) != 0) ? 8'hE0 : 8'hF0;
         else b = 8'($urandom_range(0, 255));
         send_frame(b, kind);
         if (f % 10 == 9) begin
            drain_en = 1'b0;
            checkpoint("random");
         end
      end
      wait_drain();
      checkpoint("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
